// File: rtl/ftdi601q_tx_arbiter_if.sv
// ftdi601q_tx_arbiter_if
// Groups the per-channel streaming inputs and the USB TX FIFO write port that
// the arbiter sits between.
//   ch_valid_i[3:0]    per-channel word valid (bit n = channel n)
//   ch_data_i[127:0]   per-channel word, channel n on [32n+31:32n]
//   ch_last_i[3:0]     per-channel last word of packet, qualified by valid
//   ch_ready_o[3:0]    per-channel accept
//   tx_prog_full       TX FIFO programmable-full backpressure
//   tx_en              TX FIFO write enable
//   tx_din[31:0]       TX FIFO write data
// Modports: master = channel sources + FIFO side, slave = arbiter.
interface ftdi601q_tx_arbiter_if;
  logic [3:0]   ch_valid_i;
  logic [127:0] ch_data_i;
  logic [3:0]   ch_last_i;
  logic [3:0]   ch_ready_o;
  logic         tx_prog_full;
  logic         tx_en;
  logic [31:0]  tx_din;

  modport master (
    output ch_valid_i, ch_data_i, ch_last_i, tx_prog_full,
    input  ch_ready_o, tx_en, tx_din
  );

  modport slave (
    input  ch_valid_i, ch_data_i, ch_last_i, tx_prog_full,
    output ch_ready_o, tx_en, tx_din
  );
endinterface

// File: rtl/ftdi601q_tx_arbiter.sv
// ftdi601q_tx_arbiter
// Round-robin arbiter that merges four 32-bit packet streams into a single
// USB TX FIFO write port. Each grant writes an optional header word followed
// by up to MAX_BURST payload words; a packet longer than MAX_BURST resumes on
// the channel's next grant.
// Ports:
//   sys_clk_i  single clock (same domain as the TX FIFO write port)
//   rst_i      synchronous, active-high reset
//   bus        ftdi601q_tx_arbiter_if.slave (channel streams + TX FIFO port)
//   grant_o    one-hot current grant, 0 when idle
//   busy_o     high whenever the FSM is not in IDLE
// Parameter: MAX_BURST (1..1024) payload words per grant.
// Build option: define FTDI601Q_TX_ARB_HDR_EN to include the HDR state, the
// header word {16'hA55A, seq[7:0], 6'b0, ch[1:0]} and per-channel sequence
// counters. Undefined: IDLE goes straight to DATA, only payload is written.
module ftdi601q_tx_arbiter #(
  parameter int MAX_BURST = 256
) (
  input  logic                        sys_clk_i,
  input  logic                        rst_i,
  ftdi601q_tx_arbiter_if.slave        bus,
  output logic [3:0]                  grant_o,
  output logic                        busy_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef FTDI601Q_TX_ARB_HDR_EN
    HDR  = 2'd1,
`endif
    DATA = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       rr_last;     // last granted channel
  logic [1:0]       gnt_idx;     // binary form of grant_o
  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic             found;
  logic [CNT_W-1:0] burst_cnt;
  logic             hs;
  logic             burst_end;
  logic [31:0]      gnt_data;
  logic             gnt_last;

`ifdef FTDI601Q_TX_ARB_HDR_EN
  logic [7:0]       seq [4];
`endif

  // Rotating priority: first valid channel at or after rr_last + 1.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    win_idx = rr_last + 2'd1;
    cand    = '0;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = rr_last + 2'd1 + 2'(i);
      if (!found && bus.ch_valid_i[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  assign bus.ch_ready_o = (state == DATA && !bus.tx_prog_full) ? grant_o : 4'b0000;
  assign busy_o         = (state != IDLE);

  assign gnt_data  = bus.ch_data_i[{gnt_idx, 5'b00000} +: 32];
  assign gnt_last  = bus.ch_last_i[gnt_idx];
  assign hs        = |(bus.ch_valid_i & bus.ch_ready_o);
  // Last word and the MAX_BURST-th word may coincide; either ends the burst once.
  assign burst_end = hs && (gnt_last || burst_cnt == CNT_W'(MAX_BURST - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (|bus.ch_valid_i) begin
`ifdef FTDI601Q_TX_ARB_HDR_EN
          state_nxt = HDR;
`else
          state_nxt = DATA;
`endif
        end
      end
`ifdef FTDI601Q_TX_ARB_HDR_EN
      HDR:  if (!bus.tx_prog_full) state_nxt = DATA;
`endif
      DATA: if (burst_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, burst counting and the registered FIFO write port.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      grant_o    <= '0;
      gnt_idx    <= '0;
      rr_last    <= 2'd3;          // so channel 0 wins the first search
      burst_cnt  <= '0;
      bus.tx_en  <= 1'b0;
      bus.tx_din <= '0;
`ifdef FTDI601Q_TX_ARB_HDR_EN
      // NOTE: the sequence counters are a small register array that must restart at 0, so it is reset explicitly.
      for (int i = 0; i < 4; i++) seq[i] <= '0;
`endif
    end else begin
      bus.tx_en <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.ch_valid_i) begin
            gnt_idx   <= win_idx;
            grant_o   <= 4'b0001 << win_idx;
            rr_last   <= win_idx;
            burst_cnt <= '0;
          end
        end
`ifdef FTDI601Q_TX_ARB_HDR_EN
        HDR: begin
          if (!bus.tx_prog_full) begin
            bus.tx_en    <= 1'b1;
            bus.tx_din   <= {16'hA55A, seq[gnt_idx], 6'b000000, gnt_idx};
            seq[gnt_idx] <= seq[gnt_idx] + 8'd1;
          end
        end
`endif
        DATA: begin
          if (hs) begin
            bus.tx_en  <= 1'b1;
            bus.tx_din <= gnt_data;
            burst_cnt  <= burst_cnt + CNT_W'(1);
            if (burst_end) grant_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ftdi601q_tx_arbiter.sv
module tb_ftdi601q_tx_arbiter;

  localparam int MAX_BURST = 4;
`ifdef FTDI601Q_TX_ARB_HDR_EN
  localparam bit HDR_ON = 1'b1;
`else
  localparam bit HDR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] grant;
  logic       busy;

  always #5 clk = ~clk;

  ftdi601q_tx_arbiter_if bus ();

  ftdi601q_tx_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .sys_clk_i (clk),
    .rst_i     (rst),
    .bus       (bus),
    .grant_o   (grant),
    .busy_o    (busy)
  );

  int          checks = 0;
  int          errors = 0;
  int          tx_count = 0;
  logic [31:0] exp_q [$];
  logic [31:0] src_data [4][$];
  logic        src_last [4][$];
  logic [7:0]  seq_m [4];
  logic [3:0]  hs_pending = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: records handshakes for the source model and scores FIFO writes.
  always @(negedge clk) begin
    hs_pending = bus.ch_valid_i & bus.ch_ready_o;
    if (bus.tx_en === 1'b1) begin
      tx_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %h expected no write", bus.tx_din);
      end else begin
        check("tx_din", bus.tx_din, exp_q.pop_front());
      end
    end
  end

  function automatic void drive();
    for (int c = 0; c < 4; c++) begin
      bus.ch_valid_i[c] = (src_data[c].size() > 0);
      bus.ch_last_i[c]  = (src_data[c].size() > 0) ? src_last[c][0] : 1'b0;
      bus.ch_data_i[c*32 +: 32] = (src_data[c].size() > 0) ? src_data[c][0] : 32'h0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (hs_pending[c] && src_data[c].size() > 0) begin
        void'(src_data[c].pop_front());
        void'(src_last[c].pop_front());
      end
    end
    drive();
  endtask

  // Queue a packet on a channel and push the expected FIFO stream:
  // each MAX_BURST chunk gets its own header when headers are enabled.
  task automatic send(input int ch, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      if (HDR_ON && (i % MAX_BURST) == 0) begin
        exp_q.push_back({16'hA55A, seq_m[ch], 6'b000000, 2'(ch)});
        seq_m[ch] = seq_m[ch] + 8'd1;
      end
      exp_q.push_back(base + 32'(i));
      src_data[ch].push_back(base + 32'(i));
      src_last[ch].push_back(i == n - 1);
    end
    drive();
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 50) begin tick(); n++; end
    if (!busy) timeout(name);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0 ||
            src_data[0].size() + src_data[1].size() + src_data[2].size() + src_data[3].size() != 0)
           && n < 300) begin
      tick(); n++;
    end
    if (busy || exp_q.size() != 0) timeout(name);
  endtask

  task automatic wait_tx(input int target, input string name);
    int n = 0;
    while (tx_count < target && n < 100) begin tick(); n++; end
    if (tx_count < target) timeout(name);
  endtask

  // Hold reset across one edge, clear the models, then check every output.
  task automatic do_reset(input string name);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      src_data[c].delete();
      src_last[c].delete();
      seq_m[c] = 8'h00;
    end
    hs_pending = '0;
    drive();
    @(negedge clk);
    check({name, "_tx_en"},  32'(bus.tx_en),      32'h0);
    check({name, "_tx_din"}, bus.tx_din,          32'h0);
    check({name, "_grant"},  32'(grant),          32'h0);
    check({name, "_busy"},   32'(busy),           32'h0);
    check({name, "_ready"},  32'(bus.ch_ready_o), 32'h0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus.tx_prog_full = 1'b0;
    bus.ch_valid_i   = '0;
    bus.ch_data_i    = '0;
    bus.ch_last_i    = '0;
    for (int c = 0; c < 4; c++) seq_m[c] = 8'h00;
    tick();
    do_reset("reset");

    // Single 3-word packet on channel 2.
    send(2, 3, 32'h2000_00D0);
    wait_busy("ch2_grant_wait");
    @(negedge clk);
    check("ch2_grant", 32'(grant), 32'h4);
    wait_idle("ch2_burst");
    @(negedge clk);
    check("ch2_grant_clear", 32'(grant), 32'h0);

    // Round-robin with all channels valid and 1-word packets: 0,1,2,3,0.
    do_reset("rr_reset");
    send(0, 1, 32'h0000_1000);
    send(1, 1, 32'h0000_1100);
    send(2, 1, 32'h0000_1200);
    send(3, 1, 32'h0000_1300);
    send(0, 1, 32'h0000_1001);
    wait_busy("rr_grant_wait");
    @(negedge clk);
    check("rr_first_grant", 32'(grant), 32'h1);
    wait_idle("rr_burst");

    // 6-word packet split across two bursts of MAX_BURST = 4.
    send(1, 6, 32'h1111_0000);
    wait_idle("truncate_burst");

    // 10-word packet with a 5-cycle backpressure stall after the 2nd word.
    base = tx_count;
    send(3, 10, 32'h3333_0000);
    wait_tx(base + (HDR_ON ? 3 : 2), "stall_start");
    bus.tx_prog_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      check("stall_ready", 32'(bus.ch_ready_o), 32'h0);
    end
    tick();
    bus.tx_prog_full = 1'b0;
    wait_idle("stall_burst");

    // Reset during the 3rd data word of a burst, then channel 0 wins with seq 0.
    base = tx_count;
    send(1, 4, 32'h4444_0000);
    wait_tx(base + (HDR_ON ? 3 : 2), "midburst_start");
    do_reset("midburst_reset");
    send(0, 1, 32'h5555_0000);
    send(2, 1, 32'h5555_0002);
    wait_busy("post_reset_grant_wait");
    @(negedge clk);
    check("post_reset_grant", 32'(grant), 32'h1);
    wait_idle("post_reset_burst");

    // Two words on channel 3.
    send(3, 2, 32'h7777_00D0);
    wait_idle("ch3_burst");

    repeat (3) tick();
    check("exp_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ftdi601q_tx_arbiter.md
FTDI601Q_TX_ARBITER -- requirements
Module: ftdi601q_tx_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 256, max data words per grant (legal 1..1024).
REQ-002 sys_clk_i  input  1  single clock for all logic (same domain as the USB TX FIFO write port, tx_clk).
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 ch_valid_i  input  4  per-channel word valid; bit n = channel n.
REQ-005 ch_data_i  input  128  per-channel word; channel n on bits [32n+31:32n].
REQ-006 ch_last_i  input  4  per-channel last word of packet, qualified by ch_valid_i.
REQ-007 ch_ready_o  output  4  per-channel accept; a word transfers when valid and ready are both high.
REQ-008 tx_prog_full  input  1  TX FIFO programmable-full backpressure.
REQ-009 tx_en  output  1  TX FIFO write enable.
REQ-010 tx_din  output  32  TX FIFO write data.
REQ-011 grant_o  output  4  one-hot current grant; 0 when idle.
REQ-012 busy_o  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states: IDLE, HDR, DATA; one state register.
REQ-014 IDLE: if any ch_valid_i is set, latch the winner into grant_o and go to HDR; otherwise stay in IDLE.
REQ-015 Round-robin: search starts at channel (last granted + 1) mod 4 and picks the first set bit; the pointer updates only on grant.
REQ-016 HDR: when tx_prog_full is low, write the header word and go to DATA; otherwise hold.
REQ-017 Header word: [31:16] = 16'hA55A, [15:8] = per-channel 8-bit burst sequence, [7:2] = 0, [1:0] = channel index.
REQ-018 The sequence counter of the granted channel increments when its header is written; it wraps 255 -> 0.
REQ-019 DATA: ch_ready_o[g] = (state == DATA) & ~tx_prog_full for the granted channel g; all other bits are 0, and all bits are 0 in every other state.
REQ-020 Accepted words are written with tx_en = 1 and tx_din = the word one cycle after the handshake (registered outputs, latency 1).
REQ-021 A burst counter counts accepted words and ends the burst on whichever comes first: a word accepted with last, or the MAX_BURST-th word.
REQ-022 If last and MAX_BURST coincide on the same word, the burst ends once; no extra action.
REQ-023 At burst end, return to IDLE and clear grant_o; IDLE lasts at least one cycle between bursts.
REQ-024 A packet truncated by MAX_BURST continues on that channel's next grant, with a new header.
REQ-025 tx_prog_full high mid-burst stalls the transfer; no word is dropped or duplicated.
REQ-026 ch_valid_i dropping mid-burst: stay in DATA waiting; there is no timeout and no re-arbitration.
REQ-027 Valid or data changes on non-granted channels are ignored while busy.
REQ-028 tx_en is never high in two consecutive cycles for the same accepted word.
REQ-029 tx_en is never high unless a header was written or a handshake occurred in the previous cycle.

Reset
REQ-030 While rst_i is high at a sys_clk_i edge: state = IDLE, tx_en = 0, tx_din = 0, grant_o = 0, busy_o = 0, ch_ready_o = 0.
REQ-031 Reset also sets: round-robin pointer such that channel 0 wins first, burst counter = 0, all sequence counters = 0.
REQ-032 Reset asserted mid-burst aborts the burst immediately; the partial burst is not completed after release.

Configuration
REQ-033 Macro FTDI601Q_TX_ARB_HDR_EN defined: HDR state, header word and sequence counters are present as specified above.
REQ-034 Macro FTDI601Q_TX_ARB_HDR_EN undefined:
- HDR state and sequence counters are removed.
- IDLE goes directly to DATA.
- Only payload words are written.
- All other behaviour is unchanged.

Verification
REQ-035 Macro on; ch2 sends 3 words D0..D2 with last on D2, tx_prog_full = 0 -> tx_din sequence A55A0002, D0, D1, D2, each with tx_en; grant_o = 4'b0100 during the burst, then 0.
REQ-036 Macro on; all 4 channels continuously valid, 1-word packets -> headers carry channels 0,1,2,3,0 in that order; channel 0's second header has seq 0x01.
REQ-037 MAX_BURST = 4; ch1 sends a 6-word packet -> 2 bursts: header + 4 words, then header (seq 0x01) + 2 words.
REQ-038 tx_prog_full forced high for 5 cycles after the 2nd data word of a 10-word burst -> ch_ready_o = 0 for those 5 cycles; all 10 words appear exactly once, in order.
REQ-039 rst_i pulsed during word 3 of a burst -> next cycle all outputs = 0, state = IDLE; the next grant goes to channel 0 if valid, with seq 0x00.
REQ-040 Macro off; ch3 sends 2 words -> tx_din = D0, D1 only; no A55A word is written.
